// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//
// Shared definitions for the MMIO UART transmit queue:
//   - default MMIO addresses of the transmit data and status/control words
//   - bit positions inside the status word
//   - pacer FSM state type
//   - default inter-strobe gap (one 11-bit frame at 115200 baud on 74 MHz)
//   - helper that packs the status word
// ---------------------------------------------------------------------------
package uart_pkg;

    // Store here pushes one byte into the queue.
    localparam logic [31:0] TX_ADDR_DEFAULT    = 32'h0001_0000;
    // Status read / control write.
    localparam logic [31:0] STAT_ADDR_DEFAULT  = 32'h0001_0004;

    // 11 * ceil(74e6 / 115200) = 7073 clocks per frame; rounded up with margin.
    localparam int unsigned GAP_CYCLES_DEFAULT = 7200;

    // Status word layout.
    localparam int unsigned STAT_EMPTY     = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_OVF       = 2;
    localparam int unsigned STAT_COUNT_LSB = 8;

    // Pacer: IDLE may issue a byte, WAIT burns the inter-frame gap.
    typedef enum logic {
        PACE_IDLE = 1'b0,
        PACE_WAIT = 1'b1
    } pace_state_e;

    // {16'b0, count[7:0], 5'b0, overflow, full, empty}
    function automatic logic [31:0] status_word(
        input logic [7:0] count,
        input logic       ovf,
        input logic       full,
        input logic       empty
    );
        logic [31:0] w;
        w                          = '0;
        w[STAT_EMPTY]              = empty;
        w[STAT_FULL]               = full;
        w[STAT_OVF]                = ovf;
        w[STAT_COUNT_LSB +: 8]     = count;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//
// Single-clock FIFO with a registered occupancy count. Push and pop may
// happen in the same cycle; both take effect and the count is unchanged.
// Full/empty are derived from the registered count only, so a push while
// full is refused even if a pop retires an entry in the same cycle.
//
// Parameters:
//   WIDTH    data width
//   DEPTH    number of entries, power of two, >= 2
//
// Ports:
//   clk_i     in   1            clock
//   rst_ni    in   1            asynchronous active-low reset
//   push_i    in   1            write wdata_i at the tail (ignored when full)
//   pop_i     in   1            retire the head entry (ignored when empty)
//   wdata_i   in   WIDTH        data to push
//   rdata_o   out  WIDTH        current head entry (valid when !empty_o)
//   count_o   out  log2(D)+1    number of stored entries
//   full_o    out  1            count_o == DEPTH
//   empty_o   out  1            count_o == 0
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i  && !empty;

    // Pointers are exactly AW bits wide, so wrapping modulo DEPTH is free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full;
    assign empty_o = empty;

endmodule

// File: rtl/uart_tx_queue.sv
// ---------------------------------------------------------------------------
// uart_tx_queue
//
// MMIO transmit queue in front of the UART byte transmitter. Byte stores to
// TX_ADDR are buffered in a FIFO; a pacer issues them to the transmitter as
// single-cycle write strobes spaced GAP_CYCLES clocks apart, because the
// transmitter has no busy indication. STAT_ADDR reads back queue status and
// accepts a write-1-to-clear of the sticky overflow flag.
//
// Parameters:
//   TX_ADDR      MMIO address of the byte push
//   STAT_ADDR    MMIO address of the status/control word
//   DEPTH        FIFO entries, power of two, 2..256
//   GAP_CYCLES   clocks between successive uart_wr_o pulses, >= 2
//                (>= 7073 to cover a full frame at 115200 baud / 74 MHz)
//
// Ports:
//   sys_clk_i     in   1    system clock
//   sys_rstn_i    in   1    asynchronous active-low reset
//   mmio_we_i     in   1    store strobe, one cycle per store
//   mmio_addr_i   in   32   store/load address
//   mmio_wdata_i  in   32   store data
//   mmio_rdata_o  out  32   status word when addressed, else 0 (combinational)
//   uart_wr_o     out  1    registered one-cycle write strobe
//   uart_dat_o    out  8    registered byte, valid while uart_wr_o = 1
//   fifo_full_o   out  1    FIFO holds DEPTH entries
// ---------------------------------------------------------------------------
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter logic [31:0] TX_ADDR    = TX_ADDR_DEFAULT,
    parameter logic [31:0] STAT_ADDR  = STAT_ADDR_DEFAULT,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
    input  logic        sys_clk_i,
    input  logic        sys_rstn_i,
    input  logic        mmio_we_i,
    input  logic [31:0] mmio_addr_i,
    input  logic [31:0] mmio_wdata_i,
    output logic [31:0] mmio_rdata_o,
    output logic        uart_wr_o,
    output logic [7:0]  uart_dat_o,
    output logic        fifo_full_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES);

    // The issue cycle and the cycle that returns to IDLE are both part of
    // the gap, so WAIT counts GAP_CYCLES-2 down to zero. That puts the next
    // issue exactly GAP_CYCLES edges after the previous one.
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 2);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic tx_store;
    logic stat_store;
    logic stat_sel;

    assign stat_sel   = (mmio_addr_i == STAT_ADDR);
    assign tx_store   = mmio_we_i && (mmio_addr_i == TX_ADDR);
    assign stat_store = mmio_we_i && stat_sel;

    // Only the low byte is pushed and only bit 2 is a control bit.
    logic unused_wdata;
    assign unused_wdata = ^mmio_wdata_i[31:8];

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic          fifo_pop;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (sys_clk_i),
        .rst_ni  (sys_rstn_i),
        .push_i  (tx_store),
        .pop_i   (fifo_pop),
        .wdata_i (mmio_wdata_i[7:0]),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Sticky overflow flag
    // ------------------------------------------------------------------
    logic ovf_q, ovf_d;

    // Set is evaluated after clear so a simultaneous overflow wins.
    always_comb begin
        ovf_d = ovf_q;
        if (stat_store && mmio_wdata_i[STAT_OVF]) begin
            ovf_d = 1'b0;
        end
        if (tx_store && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pacer FSM and output registers
    // ------------------------------------------------------------------
    pace_state_e   state_q, state_d;
    logic [GW-1:0] gap_q,   gap_d;
    logic          wr_q,    wr_d;
    logic [7:0]    dat_q,   dat_d;

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        wr_d     = 1'b0;
        dat_d    = dat_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            PACE_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    wr_d     = 1'b1;
                    dat_d    = fifo_head;
                    gap_d    = GAP_LOAD;
                    state_d  = PACE_WAIT;
                end
            end
            PACE_WAIT: begin
                if (gap_q == '0) begin
                    state_d = PACE_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = PACE_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state_q <= PACE_IDLE;
            gap_q   <= '0;
            wr_q    <= 1'b0;
            dat_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            wr_q    <= wr_d;
            dat_q   <= dat_d;
            ovf_q   <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        mmio_rdata_o = '0;
        if (stat_sel) begin
            mmio_rdata_o = status_word(8'(fifo_count), ovf_q, fifo_full, fifo_empty);
        end
    end

    assign uart_wr_o   = wr_q;
    assign uart_dat_o  = dat_q;
    assign fifo_full_o = fifo_full;

endmodule

// File: tb/tb_uart_tx_queue.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_queue
//
// Self-checking bench for uart_tx_queue. A behavioural model keeps the queue
// as a byte list and the pacing as "earliest edge at which the next byte may
// go out"; it logs the expected strobe edge and byte for every transmission.
// A monitor logs the observed strobes, and each test task compares the two
// logs and the status word inline.
// ---------------------------------------------------------------------------
module tb_uart_tx_queue;

    localparam logic [31:0] TX_A   = 32'h0001_0000;
    localparam logic [31:0] STAT_A = 32'h0001_0004;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned GAP    = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        wr;
    logic [7:0]  dat;
    logic        full;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    uart_tx_queue #(
        .TX_ADDR    (TX_A),
        .STAT_ADDR  (STAT_A),
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .sys_clk_i    (clk),
        .sys_rstn_i   (rst_n),
        .mmio_we_i    (we),
        .mmio_addr_i  (addr),
        .mmio_wdata_i (wdata),
        .mmio_rdata_o (rdata),
        .uart_wr_o    (wr),
        .uart_dat_o   (dat),
        .fifo_full_o  (full)
    );

    // ------------------------------------------------------------------
    // Reference model: edge index, byte list, overflow, pacing deadline
    // ------------------------------------------------------------------
    typedef struct {
        int unsigned c;
        logic [7:0]  b;
    } ev_t;

    int unsigned cyc = 0;
    logic [7:0]  mq[$];
    bit          m_ovf = 1'b0;
    int unsigned next_issue = 0;
    bit          full_pre;
    logic [7:0]  pop_b;
    ev_t         exp_ev[$];
    ev_t         act_ev[$];
    int          dbl_cnt = 0;
    logic        prev_wr = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf      = 1'b0;
            next_issue = 0;
        end else begin
            full_pre = (mq.size() == DEPTH);
            if (mq.size() != 0 && cyc >= next_issue) begin
                pop_b = mq.pop_front();
                exp_ev.push_back('{cyc, pop_b});
                next_issue = cyc + GAP;
            end
            if (we && addr == TX_A) begin
                if (full_pre) m_ovf = 1'b1;
                else          mq.push_back(wdata[7:0]);
            end else if (we && addr == STAT_A && wdata[2]) begin
                m_ovf = 1'b0;
            end
        end
        cyc++;
    end

    always @(negedge rst_n) begin
        mq.delete();
        m_ovf      = 1'b0;
        next_issue = 0;
    end

    always @(negedge clk) begin
        if (wr) act_ev.push_back('{cyc - 1, dat});
        if (wr && prev_wr) dbl_cnt++;
        prev_wr = wr;
    end

    function automatic logic [31:0] model_stat();
        logic [31:0] s;
        s       = '0;
        s[15:8] = 8'(mq.size());
        s[2]    = m_ovf;
        s[1]    = (mq.size() == DEPTH);
        s[0]    = (mq.size() == 0);
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive_store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; addr = a; wdata = d;
    endtask

    task automatic drive_idle();
        @(negedge clk);
        we = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic read_stat(output logic [31:0] v);
        @(negedge clk);
        we = 1'b0; addr = STAT_A; wdata = '0;
        #1 v = rdata;
    endtask

    task automatic wait_act(input int n, input int unsigned budget);
        for (int unsigned i = 0; i < budget && act_ev.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic settle();
        for (int unsigned i = 0; i < 20000 && !(mq.size() == 0 && cyc > next_issue + 2); i++)
            @(negedge clk);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        exp_ev.delete();
        act_ev.delete();
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        addr = STAT_A;
        #1;
        tests_run++; if (wr !== 1'b0) begin tests_failed++; $display("FAIL reset_wr: got %b expected 0", wr); end
        tests_run++; if (dat !== 8'h00) begin tests_failed++; $display("FAIL reset_dat: got %h expected 00", dat); end
        tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b expected 0", full); end
        tests_run++; if (rdata !== 32'h0000_0001) begin tests_failed++; $display("FAIL reset_stat: got %h expected 00000001", rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        addr = TX_A;
        #1;
        tests_run++; if (rdata !== 32'h0) begin tests_failed++; $display("FAIL rdata_other_addr: got %h expected 00000000", rdata); end
        tests_run++; if (wr !== 1'b0) begin tests_failed++; $display("FAIL post_reset_wr: got %b expected 0", wr); end
        addr = '0;
    endtask

    task automatic test_single();
        int unsigned t;
        logic [31:0] v;
        settle(); clear_logs();
        drive_store(TX_A, 32'h0000_0041);
        t = cyc;
        drive_idle();
        wait_act(1, 10);
        tests_run++; if (act_ev.size() != 1) begin tests_failed++; $display("FAIL single_strobes: got %0d expected 1", act_ev.size()); end
        if (act_ev.size() > 0) begin
            tests_run++; if (act_ev[0].c !== t + 1) begin tests_failed++; $display("FAIL single_latency: strobe edge %0d expected %0d", act_ev[0].c, t + 1); end
            tests_run++; if (act_ev[0].b !== 8'h41) begin tests_failed++; $display("FAIL single_data: got %h expected 41", act_ev[0].b); end
        end
        repeat (4) @(negedge clk);
        read_stat(v);
        tests_run++; if (v !== 32'h0000_0001) begin tests_failed++; $display("FAIL single_stat: got %h expected 00000001", v); end
    endtask

    task automatic test_burst();
        int unsigned t0;
        logic [31:0] v;
        settle(); clear_logs();
        for (int i = 0; i < 5; i++) begin
            drive_store(TX_A, 32'h30 + i);
            if (i == 0) t0 = cyc;
        end
        drive_idle();
        for (int k = 0; k < 5; k++) begin
            wait_act(k + 1, GAP + 10);
            tests_run++;
            if (act_ev.size() <= k) begin
                tests_failed++; $display("FAIL burst_strobe%0d: got %0d strobes expected %0d", k, act_ev.size(), k + 1);
            end else if (act_ev[k].c !== t0 + 1 + k * GAP || act_ev[k].b !== 8'(8'h30 + k)) begin
                tests_failed++; $display("FAIL burst_strobe%0d: got edge %0d byte %h expected edge %0d byte %h",
                                         k, act_ev[k].c, act_ev[k].b, t0 + 1 + k * GAP, 8'(8'h30 + k));
            end
            repeat (3) @(negedge clk);
            read_stat(v);
            tests_run++; if (v[15:8] !== 8'(4 - k)) begin tests_failed++; $display("FAIL burst_count%0d: got %0d expected %0d", k, v[15:8], 4 - k); end
            tests_run++; if (v !== model_stat()) begin tests_failed++; $display("FAIL burst_stat%0d: got %h expected %h", k, v, model_stat()); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        settle(); clear_logs();
        for (int i = 0; i < 20; i++) drive_store(TX_A, 32'(i));
        drive_idle();
        read_stat(v);
        tests_run++; if (v !== 32'h0000_1006) begin tests_failed++; $display("FAIL ovf_stat: got %h expected 00001006", v); end
        tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL ovf_full_pin: got %b expected 1", full); end
        drive_store(STAT_A, 32'h0000_0004);
        drive_idle();
        read_stat(v);
        tests_run++; if (v !== 32'h0000_1002) begin tests_failed++; $display("FAIL ovf_clear: got %h expected 00001002", v); end
        settle();
        tests_run++; if (act_ev.size() != 17) begin tests_failed++; $display("FAIL ovf_tx_count: got %0d expected 17", act_ev.size()); end
        for (int i = 0; i < 17 && i < act_ev.size(); i++) begin
            tests_run++; if (act_ev[i].b !== 8'(i)) begin tests_failed++; $display("FAIL ovf_tx_byte%0d: got %h expected %h", i, act_ev[i].b, 8'(i)); end
        end
        foreach (exp_ev[i]) if (i < act_ev.size()) begin
            tests_run++; if (act_ev[i].c !== exp_ev[i].c) begin tests_failed++; $display("FAIL ovf_tx_edge%0d: got %0d expected %0d", i, act_ev[i].c, exp_ev[i].c); end
        end
    endtask

    // Keep pushing while full across pop edges: a push on a pop edge while
    // the registered count is DEPTH must be dropped.
    task automatic test_full_pop();
        logic [31:0] v;
        settle(); clear_logs();
        for (int i = 0; i < 160; i++) drive_store(TX_A, $urandom);
        drive_idle();
        read_stat(v);
        tests_run++; if (v !== model_stat()) begin tests_failed++; $display("FAIL fullpop_stat: got %h expected %h", v, model_stat()); end
        drive_store(STAT_A, $urandom | 32'h4);
        drive_idle();
        settle();
        tests_run++; if (act_ev.size() != exp_ev.size()) begin tests_failed++; $display("FAIL fullpop_tx_count: got %0d expected %0d", act_ev.size(), exp_ev.size()); end
        foreach (exp_ev[i]) if (i < act_ev.size()) begin
            tests_run++;
            if (act_ev[i].c !== exp_ev[i].c || act_ev[i].b !== exp_ev[i].b) begin
                tests_failed++; $display("FAIL fullpop_tx%0d: got edge %0d byte %h expected edge %0d byte %h",
                                         i, act_ev[i].c, act_ev[i].b, exp_ev[i].c, exp_ev[i].b);
            end
        end
        read_stat(v);
        tests_run++; if (v !== 32'h0000_0001) begin tests_failed++; $display("FAIL fullpop_final_stat: got %h expected 00000001", v); end
    endtask

    task automatic test_concurrent();
        int unsigned t0;
        logic [31:0] v;
        settle(); clear_logs();
        drive_store(TX_A, 32'hA0);
        t0 = cyc;
        drive_store(TX_A, 32'hA1);
        drive_idle();
        read_stat(v);
        tests_run++; if (v !== 32'h0000_0100) begin tests_failed++; $display("FAIL conc_count1_a: got %h expected 00000100", v); end
        for (int unsigned i = 0; i < 4 * GAP && cyc < t0 + GAP; i++) @(negedge clk);
        drive_store(TX_A, 32'hA2);
        drive_idle();
        read_stat(v);
        tests_run++; if (v !== 32'h0000_0100) begin tests_failed++; $display("FAIL conc_count1_b: got %h expected 00000100", v); end
        tests_run++; if (act_ev.size() != 2) begin tests_failed++; $display("FAIL conc_strobes: got %0d expected 2", act_ev.size()); end
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 100)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) drive_store(STAT_A, $urandom);
                else                           drive_store($urandom | 32'h8000_0000, $urandom);
            end
            drive_store(TX_A, $urandom);
            drive_idle();
        end
        settle();
        tests_run++; if (act_ev.size() != exp_ev.size()) begin tests_failed++; $display("FAIL conc_tx_count: got %0d expected %0d", act_ev.size(), exp_ev.size()); end
        foreach (exp_ev[i]) if (i < act_ev.size()) begin
            tests_run++;
            if (act_ev[i].c !== exp_ev[i].c || act_ev[i].b !== exp_ev[i].b) begin
                tests_failed++; $display("FAIL conc_tx%0d: got edge %0d byte %h expected edge %0d byte %h",
                                         i, act_ev[i].c, act_ev[i].b, exp_ev[i].c, exp_ev[i].b);
            end
        end
        read_stat(v);
        tests_run++; if (v !== model_stat()) begin tests_failed++; $display("FAIL conc_stat: got %h expected %h", v, model_stat()); end
    endtask

    task automatic test_reset_mid_gap();
        int unsigned t0;
        int unsigned s;
        settle(); clear_logs();
        for (int i = 0; i < 4; i++) begin
            drive_store(TX_A, 32'hC0 + i);
            if (i == 0) t0 = cyc;
        end
        drive_idle();
        for (int unsigned i = 0; i < 4 * GAP && cyc < t0 + 1 + GAP / 2; i++) @(negedge clk);
        addr = STAT_A;
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (wr !== 1'b0) begin tests_failed++; $display("FAIL rst_gap_wr: got %b expected 0", wr); end
        tests_run++; if (dat !== 8'h00) begin tests_failed++; $display("FAIL rst_gap_dat: got %h expected 00", dat); end
        tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL rst_gap_full: got %b expected 0", full); end
        tests_run++; if (rdata !== 32'h0000_0001) begin tests_failed++; $display("FAIL rst_gap_stat: got %h expected 00000001", rdata); end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        tests_run++; if (act_ev.size() != 1) begin tests_failed++; $display("FAIL rst_gap_no_strobe: got %0d strobes expected 1", act_ev.size()); end
        drive_store(TX_A, 32'h5A);
        s = cyc;
        drive_idle();
        wait_act(2, 10);
        tests_run++;
        if (act_ev.size() < 2) begin
            tests_failed++; $display("FAIL rst_gap_after: got %0d strobes expected 2", act_ev.size());
        end else if (act_ev[1].c !== s + 1 || act_ev[1].b !== 8'h5A) begin
            tests_failed++; $display("FAIL rst_gap_after: got edge %0d byte %h expected edge %0d byte 5a", act_ev[1].c, act_ev[1].b, s + 1);
        end
        settle();
        tests_run++; if (act_ev.size() != exp_ev.size()) begin tests_failed++; $display("FAIL rst_gap_tx_count: got %0d expected %0d", act_ev.size(), exp_ev.size()); end
        foreach (exp_ev[i]) if (i < act_ev.size()) begin
            tests_run++;
            if (act_ev[i].c !== exp_ev[i].c || act_ev[i].b !== exp_ev[i].b) begin
                tests_failed++; $display("FAIL rst_gap_tx%0d: got edge %0d byte %h expected edge %0d byte %h",
                                         i, act_ev[i].c, act_ev[i].b, exp_ev[i].c, exp_ev[i].b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_full_pop();
        test_concurrent();
        test_reset_mid_gap();
        tests_run++; if (dbl_cnt !== 0) begin tests_failed++; $display("FAIL strobe_width: got %0d double-high cycles expected 0", dbl_cnt); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached with %0d tests run", tests_run);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Memory-mapped transmit queue sitting directly upstream of the UART byte transmitter. It accepts byte stores from the pipeline's MMIO path, buffers them in a small FIFO, and drives the transmitter's write strobe and data.

The transmitter exposes no busy output. This block therefore paces writes itself, spacing them by a fixed cycle count that covers one full 11-bit frame at 115200 baud on the 74 MHz system clock.

## Interface
Parameters:
- `TX_ADDR`, 32'h0001_0000, MMIO address; a store here pushes `mmio_wdata_i[7:0]`.
- `STAT_ADDR`, 32'h0001_0004, MMIO address of the status/control register.
- `DEPTH`, 16, FIFO entries; must be a power of two, from 2 to 256.
- `GAP_CYCLES`, 7200, clocks between successive `uart_wr_o` pulses. Must be ≥ 11 × ceil(74e6/115200) = 7073, and ≥ 2.

Ports:
- `sys_clk_i`  in  1  system clock, 74 MHz.
- `sys_rstn_i`  in  1  reset; asynchronous assertion, active-low.
- `mmio_we_i`  in  1  store strobe, one cycle per store.
- `mmio_addr_i`  in  32  store/load address.
- `mmio_wdata_i`  in  32  store data.
- `mmio_rdata_o`  out  32  status read data; combinational from `mmio_addr_i`.
- `uart_wr_o`  out  1  one-cycle write strobe to the transmitter; registered.
- `uart_dat_o`  out  8  byte to transmit; registered, valid while `uart_wr_o` = 1.
- `fifo_full_o`  out  1  FIFO holds `DEPTH` entries.

## Operation
- **Push:** `mmio_we_i` with `mmio_addr_i == TX_ADDR` and count < `DEPTH` writes `mmio_wdata_i[7:0]` at the tail.
  - With count == `DEPTH`, the byte is dropped and the sticky `overflow` bit is set.
  - Fullness is judged on the registered count only. A push while full is dropped even if a pop happens in the same cycle.
- **Status read:** when `mmio_addr_i == STAT_ADDR`, `mmio_rdata_o` = {16'b0, count[7:0], 5'b0, overflow, full, empty}. For any other address it is 0.
- **Control write:** a store to `STAT_ADDR` with `wdata[2]` = 1 clears `overflow`. If an overflowing push occurs in the same cycle, the set wins.
- **Pacer FSM:**
  - IDLE: if the FIFO is non-empty, pop the head, register it into `uart_dat_o`, pulse `uart_wr_o` for one cycle, load the gap counter, and go to WAIT.
  - WAIT: decrement the gap counter. At terminal count go to IDLE, so the next issue can happen on the following cycle.
- **Spacing:** with the FIFO continuously non-empty, consecutive `uart_wr_o` rising edges are exactly `GAP_CYCLES` cycles apart.
- **Simultaneous push and pop:** both take effect; the count is unchanged, including at count == 1 and count == `DEPTH`−1.
- **Pointers:** read and write pointers wrap modulo `DEPTH`. Count is log2(`DEPTH`)+1 bits wide.

## Timing
- **Reset values:** `uart_wr_o` = 0, `uart_dat_o` = 8'h00, `fifo_full_o` = 0; count, pointers and `overflow` = 0; FSM = IDLE; gap counter = 0.
- **Reset during a gap or mid-frame:** all queued bytes are discarded and the state returns to reset values immediately. The first write after reset is allowed on the cycle following the first push.
- **Latency:** store accepted at edge t with FIFO empty and FSM in IDLE → `uart_wr_o` high in the cycle after edge t+1. That is 2 cycles from the store cycle to the strobe cycle.
- **Strobe width:** `uart_wr_o` is never high for two consecutive cycles.
- **Status timing:** `fifo_full_o` and the status bits reflect registered state, updated one cycle after the push/pop edge.

## Structure
- **Shared package `uart_pkg`:**
  - `TX_ADDR` / `STAT_ADDR` defaults.
  - Status bit indices: EMPTY = 0, FULL = 1, OVF = 2, COUNT_LSB = 8.
  - Pacer state encoding: IDLE, WAIT.
  - The default `GAP_CYCLES` constant.
- **Sub-module `sync_fifo`:** parameterised by width and depth, with a push/pop/count/full/empty interface. The top level holds the address decode, overflow flag, pacer FSM and output registers.

## Test plan
1. **Single byte:** reset, then one store 0x41 to `TX_ADDR` → exactly one `uart_wr_o` pulse with `uart_dat_o` = 0x41, 2 cycles after the store. Status then reads empty = 1, count = 0.
2. **Burst and spacing:** burst of 5 stores 0x30..0x34 on consecutive cycles → 5 strobes in order, rising edges spaced exactly 7200 cycles. Count reads 4, 3, 2, 1, 0 after each pop.
3. **Overflow:** 20 back-to-back stores with `DEPTH` = 16 → bytes 0..16 transmitted (one popped early, 16 buffered) and the rest dropped. `overflow` = 1 and `fifo_full_o` is seen high. A store of 0x4 to `STAT_ADDR` → `overflow` = 0.
4. **Concurrent push and pop:** push coincident with a pop at count = 1 → count stays 1, and data order is preserved through pointer wrap (run 40 bytes through a 16-deep FIFO).
5. **Reset mid-gap:** assert `sys_rstn_i` low 3000 cycles into a gap with 3 bytes queued → outputs at reset values immediately, no further strobes. A new store after release is transmitted 2 cycles later, with no residual gap.
